// File: rtl/matrix_mult_pkg.sv
// Shared Q20.12 matrix-block definitions: element format, dimension limits,
// rounding constant and the controller state encoding.
package matrix_mult_pkg;

  localparam int FRAC_BITS = 12;
  localparam int MAX_DIM   = 6;
  localparam int MAX_ELEMS = MAX_DIM * MAX_DIM;
  localparam int DATA_W    = 32;
  localparam int PROD_W    = 2 * DATA_W;
  // Six full-scale products plus rounding headroom fit comfortably in 72 bits.
  localparam int ACC_W     = 72;
  localparam int ROUND     = 1 << (FRAC_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } mm_state_t;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'(MAX_DIM));
  endfunction

endpackage

// File: rtl/q_round_sat.sv
// Q20.12 write-back stage: round half up on the wide accumulator, drop the
// fraction bits and clamp into a signed 32-bit word.
module q_round_sat
  import matrix_mult_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] q
);

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;
  logic                    fits;

  assign rounded = acc + ACC_W'(ROUND);
  assign shifted = rounded >>> FRAC_BITS;

  // In range when every bit above the 32-bit sign bit agrees with it.
  assign fits = (&shifted[ACC_W-1:DATA_W-1]) | ~(|shifted[ACC_W-1:DATA_W-1]);

  always_comb begin
    q = shifted[DATA_W-1:0];
    if (!fits) begin
      q = shifted[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

endmodule

// File: rtl/matrix_mult.sv
// Sequential Q20.12 matrix multiplier C = A x B, one multiply-accumulate per
// cycle, with a start/done level handshake shared with the matrix adder.
module matrix_mult
  import matrix_mult_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [2:0]                    rows,
  input  logic [2:0]                    inner,
  input  logic [2:0]                    cols,
  input  logic [MAX_ELEMS*DATA_W-1:0]   Ain,
  input  logic [MAX_ELEMS*DATA_W-1:0]   Bin,
  output logic [MAX_ELEMS*DATA_W-1:0]   Cout,
  output logic                          done,
  output logic                          busy,
  output logic                          err
);

  mm_state_t state_reg, state_next;

  logic [2:0]              rows_reg, inner_reg, cols_reg;
  logic [2:0]              r_reg, c_reg, k_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [DATA_W-1:0]       a_mem    [MAX_ELEMS];
  logic [DATA_W-1:0]       b_mem    [MAX_ELEMS];
  logic [DATA_W-1:0]       cout_reg [MAX_ELEMS];
  logic                    done_reg, busy_reg, err_reg, err_pend_reg;

  logic                     dims_legal, last_k, last_c, last_r;
  logic [5:0]               a_slot, b_slot, c_slot;
  logic signed [DATA_W-1:0] a_op, b_op;
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0]        q_val;

  assign dims_legal = dim_ok(rows) && dim_ok(inner) && dim_ok(cols);

  assign last_k = (k_reg == inner_reg - 3'd1);
  assign last_c = (c_reg == cols_reg - 3'd1);
  assign last_r = (r_reg == rows_reg - 3'd1);

  assign a_slot = 6'(r_reg) * 6'(inner_reg) + 6'(k_reg);
  assign b_slot = 6'(k_reg) * 6'(cols_reg) + 6'(c_reg);
  assign c_slot = 6'(r_reg) * 6'(cols_reg) + 6'(c_reg);

  assign a_op = a_mem[a_slot];
  assign b_op = b_mem[b_slot];
  assign prod = PROD_W'(a_op) * PROD_W'(b_op);

  q_round_sat u_round_sat (
    .acc (acc_reg),
    .q   (q_val)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = dims_legal ? ST_LOAD : ST_DONE;
      ST_LOAD:  state_next = ST_MAC;
      ST_MAC:   if (last_k) state_next = ST_WRITE;
      ST_WRITE: state_next = (last_c && last_r) ? ST_DONE : ST_MAC;
      ST_DONE:  if (!start) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // done/busy/err are registered, so they trail the state register by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_reg     <= 3'd0;
      inner_reg    <= 3'd0;
      cols_reg     <= 3'd0;
      r_reg        <= 3'd0;
      c_reg        <= 3'd0;
      k_reg        <= 3'd0;
      acc_reg      <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_pend_reg <= 1'b0;
      for (int i = 0; i < MAX_ELEMS; i++) begin
        a_mem[i]    <= '0;
        b_mem[i]    <= '0;
        cout_reg[i] <= '0;
      end
    end else begin
      done_reg <= (state_reg == ST_DONE);
      busy_reg <= (state_reg == ST_LOAD) || (state_reg == ST_MAC) ||
                  (state_reg == ST_WRITE) ||
                  ((state_reg == ST_IDLE) && start && dims_legal);
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (dims_legal) begin
              rows_reg     <= rows;
              inner_reg    <= inner;
              cols_reg     <= cols;
              err_reg      <= 1'b0;
              err_pend_reg <= 1'b0;
            end else begin
              err_pend_reg <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          for (int i = 0; i < MAX_ELEMS; i++) begin
            a_mem[i]    <= Ain[i*DATA_W +: DATA_W];
            b_mem[i]    <= Bin[i*DATA_W +: DATA_W];
            cout_reg[i] <= '0;
          end
          r_reg   <= 3'd0;
          c_reg   <= 3'd0;
          k_reg   <= 3'd0;
          acc_reg <= '0;
        end
        ST_MAC: begin
          acc_reg <= acc_reg + ACC_W'(prod);
          k_reg   <= k_reg + 3'd1;
        end
        ST_WRITE: begin
          cout_reg[c_slot] <= q_val;
          acc_reg          <= '0;
          k_reg            <= 3'd0;
          if (last_c) begin
            c_reg <= 3'd0;
            r_reg <= r_reg + 3'd1;
          end else begin
            c_reg <= c_reg + 3'd1;
          end
        end
        ST_DONE: err_reg <= err_pend_reg;
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_ELEMS; gi++) begin : g_cout
      assign Cout[gi*DATA_W +: DATA_W] = cout_reg[gi];
    end
  endgenerate

  assign done = done_reg;
  assign busy = busy_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_matrix_mult.sv
// Randomized and directed checks of matrix_mult against a plain-arithmetic
// matrix product model with round-half-up and 32-bit saturation.
module tb_matrix_mult;
  import matrix_mult_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic [2:0]                  rows, inner, cols;
  logic [MAX_ELEMS*DATA_W-1:0] Ain, Bin, Cout;
  logic                        done, busy, err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] a_vals [MAX_ELEMS];
  logic [31:0] b_vals [MAX_ELEMS];
  logic [31:0] exp_c  [MAX_ELEMS];

  localparam logic signed [127:0] MAXV = 128'sd2147483647;
  localparam logic signed [127:0] MINV = -128'sd2147483648;

  matrix_mult dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rows  (rows),
    .inner (inner),
    .cols  (cols),
    .Ain   (Ain),
    .Bin   (Bin),
    .Cout  (Cout),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_q();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return $urandom_range(0, 32'h7FFFF) - 32'h40000;
  endfunction

  task automatic clear_ab();
    for (int i = 0; i < MAX_ELEMS; i++) begin
      a_vals[i] = '0;
      b_vals[i] = '0;
    end
  endtask

  task automatic random_ab();
    for (int i = 0; i < MAX_ELEMS; i++) begin
      a_vals[i] = rand_q();
      b_vals[i] = rand_q();
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < MAX_ELEMS; i++) begin
      Ain[i*32 +: 32] = a_vals[i];
      Bin[i*32 +: 32] = b_vals[i];
    end
  endtask

  // Reference: exact wide dot products, then (x + 2048) >>> 12 and clamp.
  task automatic model(input int nr, input int ni, input int nc);
    logic signed [127:0] s;
    for (int i = 0; i < MAX_ELEMS; i++) exp_c[i] = '0;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        s = '0;
        for (int k = 0; k < ni; k++)
          s += 128'($signed(a_vals[r*ni+k])) * 128'($signed(b_vals[k*nc+c]));
        s = (s + 128'sd2048) >>> 12;
        if (s > MAXV)      s = MAXV;
        else if (s < MINV) s = MINV;
        exp_c[r*nc+c] = s[31:0];
      end
    end
  endtask

  task automatic check_cout(input string tag);
    for (int i = 0; i < MAX_ELEMS; i++)
      check($sformatf("%s_c%0d", tag, i), Cout[i*32 +: 32], exp_c[i]);
  endtask

  // The next rising edge is edge 0; scramble perturbs Ain/Bin after LOAD.
  task automatic wait_done(input int exp_edge, input logic scramble, input string tag);
    logic seen, busy_prev;
    seen = 1'b0;
    busy_prev = 1'b0;
    for (int e = 0; e < 400 && !seen; e++) begin
      @(posedge clk); #1;
      if (e == 0) check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      if (e == 1 && scramble) begin
        for (int i = 0; i < MAX_ELEMS; i++) begin
          Ain[i*32 +: 32] = $urandom;
          Bin[i*32 +: 32] = $urandom;
        end
      end
      if (done) begin
        seen = 1'b1;
        check({tag, "_done_edge"}, 32'(e), 32'(exp_edge));
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_busy_before"}, 32'(busy_prev), 32'd1);
      end
      busy_prev = busy;
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check({tag, "_release"}, 32'(done), 32'd0);
  endtask

  task automatic run_op(input int nr, input int ni, input int nc, input int hold_extra, input string tag);
    @(negedge clk);
    rows  = 3'(nr);
    inner = 3'(ni);
    cols  = 3'(nc);
    drive_inputs();
    model(nr, ni, nc);
    start = 1'b1;
    wait_done(2 + nr*nc*(ni+1), 1'b0, tag);
    check_cout(tag);
    check({tag, "_err"}, 32'(err), 32'd0);
    for (int i = 0; i < hold_extra; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, 32'(done), 32'd1);
    end
    release_start(tag);
  endtask

  // Cout must keep the previous result, so exp_c is deliberately not remodelled.
  task automatic run_illegal(input int nr, input int ni, input int nc, input string tag);
    @(negedge clk);
    rows  = 3'(nr);
    inner = 3'(ni);
    cols  = 3'(nc);
    random_ab();
    drive_inputs();
    start = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      check({tag, "_busy"}, 32'(busy), 32'd0);
      if (e == 0) check({tag, "_done_e0"}, 32'(done), 32'd0);
      if (e == 1) begin
        check({tag, "_done_e1"}, 32'(done), 32'd1);
        check({tag, "_err_e1"}, 32'(err), 32'd1);
      end
    end
    check_cout(tag);
    release_start(tag);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    rows  = 3'd1;
    inner = 3'd1;
    cols  = 3'd1;
    Ain   = '0;
    Bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cout", 32'(|Cout), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    clear_ab();
    a_vals[0] = 32'h0000_1000; a_vals[3] = 32'h0000_1000;
    b_vals[0] = 32'h0000_1800; b_vals[1] = 32'h0000_2000;
    b_vals[2] = 32'hFFFF_D000; b_vals[3] = 32'h0000_0400;
    run_op(2, 2, 2, 0, "identity");

    clear_ab(); a_vals[0] = 32'h0000_0001; b_vals[0] = 32'h0000_0800;
    run_op(1, 1, 1, 0, "round_pos");
    clear_ab(); a_vals[0] = 32'hFFFF_FFFF; b_vals[0] = 32'h0000_0800;
    run_op(1, 1, 1, 0, "round_neg");
    clear_ab(); a_vals[0] = 32'h7FFF_FFFF; b_vals[0] = 32'h7FFF_FFFF;
    run_op(1, 1, 1, 0, "sat_pos");
    clear_ab(); a_vals[0] = 32'h8000_0000; b_vals[0] = 32'h7FFF_FFFF;
    run_op(1, 1, 1, 0, "sat_neg");

    clear_ab();
    for (int i = 0; i < 6; i++) a_vals[i] = 32'((i + 1) * 32'h1000);
    for (int i = 0; i < 3; i++) b_vals[i] = 32'h1000;
    run_op(2, 3, 1, 5, "nonsquare");

    run_illegal(0, 2, 2, "illegal_rows0");
    run_illegal(2, 2, 7, "illegal_cols7");

    for (int t = 0; t < 6; t++) begin
      random_ab();
      run_op($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), 0,
             $sformatf("rand%0d", t));
    end

    // Abort a 6x6x6 run at edge 100, then restart straight out of reset.
    @(negedge clk);
    rows = 3'd6; inner = 3'd6; cols = 3'd6;
    random_ab();
    drive_inputs();
    start = 1'b1;
    for (int e = 0; e <= 100; e++) begin
      @(posedge clk); #1;
    end
    check("abort_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_cout", 32'(|Cout), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy_clr", 32'(busy), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    random_ab();
    drive_inputs();
    model(6, 6, 6);
    @(negedge clk);
    rst = 1'b0;
    wait_done(254, 1'b1, "restart");
    check_cout("restart");
    release_start("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_mult.md
# matrix_mult

Sequential Q20.12 fixed-point matrix multiplier computing C = A × B, with A of size rows×inner and B of size inner×cols, each dimension 1 to 6. It sits directly downstream of the matrix adder. It consumes the adder's packed row-major sum on either operand bus and uses the same start/done level handshake, so the two blocks chain without glue logic. Arithmetic is one multiply-accumulate per cycle, with round-half-up and saturation on write-back.

## Interface
- MAX_DIM, 6, largest legal value of any dimension
- MAX_ELEMS, 36, MAX_DIM², element slots per packed bus
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  level request; sampled only in IDLE
- rows  in  3  rows of A and C
- inner  in  3  columns of A, rows of B
- cols  in  3  columns of B and C
- Ain  in  MAX_ELEMS*32  packed A; element (r,k) at slot r*inner+k, bits [slot*32 +: 32]
- Bin  in  MAX_ELEMS*32  packed B; element (k,c) at slot k*cols+c
- Cout  out  MAX_ELEMS*32  packed C; element (r,c) at slot r*cols+c
- done  out  1  result valid; held until start is low
- busy  out  1  high in LOAD, MAC and WRITE
- err  out  1  illegal dimension on the last request; valid while done is high

## Operation
- **States:**
  - IDLE, LOAD, MAC, WRITE, DONE.
- **IDLE:**
  - Hold done=0.
  - When start=1 with all dimensions in 1..6: latch rows/inner/cols, clear err, and go to LOAD.
  - When start=1 with any dimension equal to 0 or greater than 6: set err=1, go to DONE, and leave Cout unchanged.
- **LOAD:**
  - Snapshot Ain and Bin into internal arrays. Later input changes have no effect.
  - Zero all 36 Cout slots.
  - Set r=c=k=0, acc=0, and go to MAC.
- **MAC:**
  - acc += A[r][k] * B[k][c], a full 64-bit signed product.
  - k++. When k reaches inner-1, go to WRITE.
- **WRITE:**
  - Cout[r*cols+c] = sat32((acc + 2048) >>> 12), using an arithmetic shift.
  - Clear acc and k.
  - Advance c; when c wraps past cols-1, reset c and advance r.
  - After the last element, go to DONE; otherwise go back to MAC.
- **DONE:**
  - done=1. When start=0, go to IDLE.
- **Accumulator width:** at least 67 bits signed, so six worst-case products cannot overflow before rounding.
- **sat32 clamp:**
  - Values above 0x7FFFFFFF clamp to 0x7FFFFFFF.
  - Values below 0x80000000 clamp to 0x80000000.
  - There is no sticky overflow flag.
- **start during operation:** ignored while busy. A new operation needs start low, then high again.
- **Reset, including mid-operation:** immediately returns the block to IDLE with Cout=0, done=0, busy=0, err=0; in-flight work is discarded. If start is high when rst is released, the block starts a new operation on the first clock edge.

## Timing
- Edge 0 is the rising edge that samples start=1 in IDLE.
- Latency for legal dimensions: done rises at edge 2 + rows*cols*(inner+1).
  - 1×1×1: edge 4.
  - 2×2×2: edge 14.
  - 6×6×6: edge 254.
- Latency for illegal dimensions: done and err rise at edge 1.
- Cout slot updates: each slot updates at its WRITE edge. Cout is final only when done=1.
- Handshake release: done falls on the first edge after start is seen low in DONE.
- busy: rises at edge 0 and falls on the same edge that done rises.

## Structure
- **Shared package** (also used by the adder): FRAC_BITS=12, MAX_DIM, MAX_ELEMS, the Q20.12 ROUND constant 2048, and the state encoding.
- **Sub-module `q_round_sat`:** combinational. Takes the wide accumulator, adds ROUND, shifts right by FRAC_BITS, and saturates to 32 bits. The planned scaler and dot-product blocks reuse it.

## Test plan
- **Identity:** 2×2×2, A=I (0x00001000 on the diagonal), B={0x00001800, 0x00002000, 0xFFFFD000, 0x00000400} -> Cout equals B, remaining slots 0, done at edge 14.
- **Rounding:** 1×1×1.
  - A=0x00000001, B=0x00000800 -> Cout[0]=0x00000001.
  - A=0xFFFFFFFF, B=0x00000800 -> Cout[0]=0x00000000.
- **Saturation:** 1×1×1.
  - A=B=0x7FFFFFFF -> 0x7FFFFFFF.
  - A=0x80000000, B=0x7FFFFFFF -> 0x80000000.
- **Non-square:** 2×3 × 3×1, A={1,2,3,4,5,6}×0x1000, B={1,1,1}×0x1000 -> Cout[0]=0x6000, Cout[1]=0xF000, slots 2..35 zero, done at edge 10. Hold start high for 5 extra cycles and confirm done stays high; drop start and confirm done falls one edge later.
- **Illegal dimensions:** rows=0, or cols=7 -> err=1 and done=1 at edge 1, Cout unchanged, busy never asserted.
- **Reset mid-operation:**
  - Run a 6×6×6 operation and assert rst at edge 100 -> all outputs 0 asynchronously.
  - Release rst with start held high -> a fresh run completes at edge 254 relative to the restart edge, with Ain/Bin changes after LOAD ignored.
